// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe turn sequencer: FSM states, winner codes,
// board constants and small board helpers.
package ttt_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      A_TURN = 3'd1,
      B_WAIT = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic [8:0] FULL_BOARD  = 9'h1FF;
   localparam int         NUM_SQUARES = 9;

   // Square indices run row-major from the top-left; square 0 lives in board bit 8.
   localparam int SQ_TL = 0;
   localparam int SQ_TM = 1;
   localparam int SQ_TR = 2;
   localparam int SQ_ML = 3;
   localparam int SQ_MM = 4;
   localparam int SQ_MR = 5;
   localparam int SQ_BL = 6;
   localparam int SQ_BM = 7;
   localparam int SQ_BR = 8;

   function automatic logic [8:0] sq_mask(input int idx);
      return 9'b1 << (NUM_SQUARES - 1 - idx);
   endfunction

   function automatic logic is_legal(input logic [8:0] m, input logic [8:0] occ);
      return (m != 9'd0) && ((m & (m - 9'd1)) == 9'd0) && ((m & occ) == 9'd0);
   endfunction

endpackage

// File: rtl/ttt_if.sv
// Move handshake between the player A / AI front ends (master) and the game controller (slave).
interface ttt_if;
   logic       a_move_valid;
   logic [8:0] a_move;
   logic       a_move_ready;
   logic       ai_req;
   logic       ai_move_valid;
   logic [8:0] ai_move;

   modport master (
      output a_move_valid, a_move, ai_move_valid, ai_move,
      input  a_move_ready, ai_req
   );

   modport slave (
      input  a_move_valid, a_move, ai_move_valid, ai_move,
      output a_move_ready, ai_req
   );
endinterface

// File: rtl/ttt_detect_winner.sv
// Combinational line detector: reports which of the eight lines each board has completed.
module ttt_detect_winner (
   input  logic [8:0] ain,
   input  logic [8:0] bin,
   output logic [7:0] win_a,
   output logic [7:0] win_b
);

   // Bit order: rows top..bottom, columns left..right, TL-BR diagonal, TR-BL diagonal.
   function automatic logic [7:0] lines(input logic [8:0] b);
      logic [7:0] l;
      l[0] = b[8] & b[7] & b[6];
      l[1] = b[5] & b[4] & b[3];
      l[2] = b[2] & b[1] & b[0];
      l[3] = b[8] & b[5] & b[2];
      l[4] = b[7] & b[4] & b[1];
      l[5] = b[6] & b[3] & b[0];
      l[6] = b[8] & b[4] & b[0];
      l[7] = b[6] & b[4] & b[2];
      return l;
   endfunction

   assign win_a = lines(ain);
   assign win_b = lines(bin);

endmodule

// File: rtl/ttt_game_ctrl.sv
// Turn sequencer for one tic-tac-toe game: owns both boards, validates moves from
// player A and the AI, runs the AI request/timeout handshake and latches the result.
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter logic A_FIRST    = 1'b1,
   parameter int   AI_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   ttt_if.slave       move_if,
   output logic [8:0] ain,
   output logic [8:0] bin,
   output logic [7:0] win_line,
   output logic [1:0] winner,
   output logic       game_over,
   output logic       illegal_move,
   output logic       ai_timeout
);

   localparam int            TW          = $clog2(AI_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(AI_TIMEOUT);
   localparam state_t        FIRST_TURN  = A_FIRST ? A_TURN : B_WAIT;

   state_t        state, state_nx;
   logic [8:0]    ain_nx, bin_nx;
   logic [3:0]    move_cnt, move_cnt_nx, move_cnt_inc;
   logic [TW-1:0] timer, timer_nx;
   logic [7:0]    win_line_nx;
   logic [1:0]    winner_nx;
   logic          illegal_nx, timeout_nx;
   logic          last_b, last_b_nx;
   logic [8:0]    occ, fallback;
   logic [7:0]    win_a, win_b, cur_line;

   ttt_detect_winner u_detect (
      .ain   (ain),
      .bin   (bin),
      .win_a (win_a),
      .win_b (win_b)
   );

   assign occ          = ain | bin;
   assign cur_line     = last_b ? win_b : win_a;
   assign move_cnt_inc = (move_cnt == 4'd9) ? move_cnt : move_cnt + 4'd1;

   assign move_if.a_move_ready = (state == A_TURN);
   assign move_if.ai_req       = (state == B_WAIT);
   assign game_over            = (state == DONE);

   // Scanning from the highest square index down leaves the lowest-index empty square.
   always_comb begin
      fallback = 9'd0;
      for (int sq = SQ_BR; sq >= SQ_TL; sq--) begin
         if ((occ & sq_mask(sq)) == 9'd0) fallback = sq_mask(sq);
      end
   end

   always_comb begin
      state_nx    = state;
      ain_nx      = ain;
      bin_nx      = bin;
      move_cnt_nx = move_cnt;
      timer_nx    = '0;
      win_line_nx = win_line;
      winner_nx   = winner;
      illegal_nx  = 1'b0;
      timeout_nx  = 1'b0;
      last_b_nx   = last_b;

      if (start) begin
         state_nx    = FIRST_TURN;
         ain_nx      = 9'd0;
         bin_nx      = 9'd0;
         move_cnt_nx = 4'd0;
         win_line_nx = 8'd0;
         winner_nx   = WIN_NONE;
      end else begin
         case (state)
            A_TURN: begin
               if (move_if.a_move_valid) begin
                  if (is_legal(move_if.a_move, occ)) begin
                     ain_nx      = ain | move_if.a_move;
                     move_cnt_nx = move_cnt_inc;
                     last_b_nx   = 1'b0;
                     state_nx    = CHECK;
                  end else begin
                     illegal_nx = 1'b1;
                  end
               end
            end
            // A rejected AI move keeps the timer running toward the fallback.
            B_WAIT: begin
               timer_nx = timer + TW'(1);
               if (move_if.ai_move_valid && is_legal(move_if.ai_move, occ)) begin
                  bin_nx      = bin | move_if.ai_move;
                  move_cnt_nx = move_cnt_inc;
                  last_b_nx   = 1'b1;
                  state_nx    = CHECK;
                  timer_nx    = '0;
               end else begin
                  if (move_if.ai_move_valid) illegal_nx = 1'b1;
                  if (timer == TIMEOUT_VAL) begin
                     bin_nx      = bin | fallback;
                     move_cnt_nx = move_cnt_inc;
                     last_b_nx   = 1'b1;
                     timeout_nx  = 1'b1;
                     state_nx    = CHECK;
                     timer_nx    = '0;
                  end
               end
            end
            // A completed line outranks a full board.
            CHECK: begin
               if (cur_line != 8'd0) begin
                  win_line_nx = cur_line;
                  winner_nx   = last_b ? WIN_B : WIN_A;
                  state_nx    = DONE;
               end else if (move_cnt == 4'd9) begin
                  winner_nx = WIN_DRAW;
                  state_nx  = DONE;
               end else begin
                  state_nx = last_b ? A_TURN : B_WAIT;
               end
            end
            IDLE, DONE: ;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ain          <= 9'd0;
         bin          <= 9'd0;
         move_cnt     <= 4'd0;
         timer        <= '0;
         win_line     <= 8'd0;
         winner       <= WIN_NONE;
         illegal_move <= 1'b0;
         ai_timeout   <= 1'b0;
         last_b       <= 1'b0;
      end else begin
         state        <= state_nx;
         ain          <= ain_nx;
         bin          <= bin_nx;
         move_cnt     <= move_cnt_nx;
         timer        <= timer_nx;
         win_line     <= win_line_nx;
         winner       <= winner_nx;
         illegal_move <= illegal_nx;
         ai_timeout   <= timeout_nx;
         last_b       <= last_b_nx;
      end
   end

   // The move counter and the occupied-square map must always agree on a full board.
   always_ff @(posedge clk) begin
      if (rst_n) assert ((move_cnt == 4'd9) == (occ == FULL_BOARD));
   end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl (A moves first, AI timeout of 4 cycles).
module tb_ttt_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [8:0] ain, bin;
   logic [7:0] win_line;
   logic [1:0] winner;
   logic       game_over, illegal_move, ai_timeout;
   int         errors = 0;
   int         checks = 0;

   ttt_if bus ();

   ttt_game_ctrl #(.A_FIRST(1'b1), .AI_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .move_if      (bus),
      .ain          (ain),
      .bin          (bin),
      .win_line     (win_line),
      .winner       (winner),
      .game_over    (game_over),
      .illegal_move (illegal_move),
      .ai_timeout   (ai_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic a_play(input logic [8:0] m);
      int n = 0;
      while (bus.a_move_ready !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (bus.a_move_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL a_ready_wait: a_move_ready=%b, required 1", bus.a_move_ready);
      end
      bus.a_move_valid = 1'b1;
      bus.a_move       = m;
      tick();
      bus.a_move_valid = 1'b0;
      bus.a_move       = 9'd0;
   endtask

   task automatic ai_play(input logic [8:0] m);
      int n = 0;
      while (bus.ai_req !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (bus.ai_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ai_req_wait: ai_req=%b, required 1", bus.ai_req);
      end
      bus.ai_move_valid = 1'b1;
      bus.ai_move       = m;
      tick();
      bus.ai_move_valid = 1'b0;
      bus.ai_move       = 9'd0;
   endtask

   task automatic play_game(input logic [8:0] seq [9], input int n);
      for (int i = 0; i < n; i++) begin
         if (i % 2 == 0) a_play(seq[i]);
         else            ai_play(seq[i]);
      end
   endtask

   task automatic test_reset();
      bus.a_move_valid = 1'b0; bus.a_move = 9'd0;
      bus.ai_move_valid = 1'b0; bus.ai_move = 9'd0;
      rst_n = 1'b0;
      tick(); tick();
      checks++;
      if ({ain, bin} !== 18'd0) begin
         errors++; $display("[TB] FAIL reset_boards: ain=%b bin=%b, required 0", ain, bin);
      end
      checks++;
      if ({winner, win_line} !== 10'd0) begin
         errors++; $display("[TB] FAIL reset_result: winner=%b win_line=%b, required 0", winner, win_line);
      end
      checks++;
      if ({bus.a_move_ready, bus.ai_req, game_over, illegal_move, ai_timeout} !== 5'd0) begin
         errors++;
         $display("[TB] FAIL reset_flags: ready=%b req=%b over=%b ill=%b to=%b, required all 0",
                  bus.a_move_ready, bus.ai_req, game_over, illegal_move, ai_timeout);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.a_move_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL idle_ready: a_move_ready=%b, required 0", bus.a_move_ready);
      end
      pulse_start();
      checks++;
      if (bus.a_move_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL start_ready: a_move_ready=%b, required 1", bus.a_move_ready);
      end
   endtask

   task automatic test_a_win();
      pulse_start();
      a_play(9'b100000000);
      checks++;
      if ({bus.a_move_ready, bus.ai_req, ain} !== {2'b00, 9'b100000000}) begin
         errors++;
         $display("[TB] FAIL check_cycle: ready=%b req=%b ain=%b, required 0 0 100000000",
                  bus.a_move_ready, bus.ai_req, ain);
      end
      tick();
      checks++;
      if (bus.ai_req !== 1'b1) begin
         errors++; $display("[TB] FAIL ai_req_rise: ai_req=%b, required 1", bus.ai_req);
      end
      ai_play(9'b000010000);
      a_play(9'b010000000);
      ai_play(9'b000000001);
      a_play(9'b001000000);
      checks++;
      if (game_over !== 1'b0) begin
         errors++; $display("[TB] FAIL over_latency: game_over=%b in CHECK, required 0", game_over);
      end
      tick();
      checks++;
      if (ain !== 9'b111000000 || bin !== 9'b000010001) begin
         errors++; $display("[TB] FAIL a_win_boards: ain=%b bin=%b, required 111000000 000010001", ain, bin);
      end
      checks++;
      if ({win_line, winner, game_over} !== {8'b00000001, 2'b01, 1'b1}) begin
         errors++;
         $display("[TB] FAIL a_win_result: win_line=%b winner=%b over=%b, required 00000001 01 1",
                  win_line, winner, game_over);
      end
   endtask

   task automatic test_illegal();
      pulse_start();
      a_play(9'b100000000);
      ai_play(9'b000010000);
      tick();
      a_play(9'b000010000);
      checks++;
      if ({illegal_move, bus.a_move_ready, ain} !== {2'b11, 9'b100000000}) begin
         errors++;
         $display("[TB] FAIL illegal_occupied: ill=%b ready=%b ain=%b, required 1 1 100000000",
                  illegal_move, bus.a_move_ready, ain);
      end
      tick();
      checks++;
      if (illegal_move !== 1'b0) begin
         errors++; $display("[TB] FAIL illegal_pulse: illegal_move=%b, required 0", illegal_move);
      end
      a_play(9'b000000011);
      checks++;
      if ({illegal_move, bus.a_move_ready, ain} !== {2'b11, 9'b100000000}) begin
         errors++;
         $display("[TB] FAIL illegal_multihot: ill=%b ready=%b ain=%b, required 1 1 100000000",
                  illegal_move, bus.a_move_ready, ain);
      end
      tick();
      checks++;
      if ({illegal_move, bus.a_move_ready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL illegal_end: ill=%b ready=%b, required 0 1", illegal_move, bus.a_move_ready);
      end
   endtask

   task automatic test_timeout();
      int  req_cycles = 0;
      bit  seen = 0;
      pulse_start();
      a_play(9'b100000000);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.ai_req === 1'b1) begin req_cycles++; seen = 1; end
         else if (seen) break;
      end
      checks++;
      if (req_cycles !== 5) begin
         errors++; $display("[TB] FAIL timeout_req_len: ai_req cycles=%0d, required 5", req_cycles);
      end
      checks++;
      if ({ai_timeout, bin} !== {1'b1, 9'b010000000}) begin
         errors++;
         $display("[TB] FAIL timeout_move: ai_timeout=%b bin=%b, required 1 010000000", ai_timeout, bin);
      end
      tick();
      checks++;
      if ({ai_timeout, bus.a_move_ready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL timeout_pulse: ai_timeout=%b ready=%b, required 0 1", ai_timeout, bus.a_move_ready);
      end
   endtask

   task automatic test_draw();
      logic [8:0] seq [9] = '{9'b010000000, 9'b100000000, 9'b000100000, 9'b001000000,
                              9'b000001000, 9'b000010000, 9'b000000100, 9'b000000010,
                              9'b000000001};
      pulse_start();
      play_game(seq, 9);
      tick();
      checks++;
      if (ain !== 9'b010101101 || bin !== 9'b101010010) begin
         errors++; $display("[TB] FAIL draw_boards: ain=%b bin=%b, required 010101101 101010010", ain, bin);
      end
      checks++;
      if ({winner, win_line, game_over} !== {2'b11, 8'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL draw_result: winner=%b win_line=%b over=%b, required 11 00000000 1",
                  winner, win_line, game_over);
      end
      checks++;
      if (dut.move_cnt !== 4'd9) begin
         errors++; $display("[TB] FAIL draw_count: move_cnt=%0d, required 9", dut.move_cnt);
      end
   endtask

   task automatic test_b_win();
      logic [8:0] seq [9] = '{9'b100000000, 9'b000010000, 9'b010000000, 9'b001000000,
                              9'b000000001, 9'b000000100, 9'd0, 9'd0, 9'd0};
      pulse_start();
      play_game(seq, 6);
      tick();
      checks++;
      if ({win_line, winner, game_over, bin} !== {8'b10000000, 2'b10, 1'b1, 9'b001010100}) begin
         errors++;
         $display("[TB] FAIL b_win: win_line=%b winner=%b over=%b bin=%b, required 10000000 10 1 001010100",
                  win_line, winner, game_over, bin);
      end
   endtask

   task automatic test_win_full_board();
      logic [8:0] seq [9] = '{9'b100000000, 9'b000100000, 9'b010000000, 9'b000010000,
                              9'b000001000, 9'b000000010, 9'b000000100, 9'b000000001,
                              9'b001000000};
      pulse_start();
      play_game(seq, 9);
      tick();
      checks++;
      if ({win_line, winner, game_over, ain | bin} !== {8'b00000001, 2'b01, 1'b1, 9'h1FF}) begin
         errors++;
         $display("[TB] FAIL win_full: win_line=%b winner=%b over=%b occ=%b, required 00000001 01 1 111111111",
                  win_line, winner, game_over, ain | bin);
      end
   endtask

   task automatic test_start_in_bwait();
      pulse_start();
      a_play(9'b000010000);
      tick();
      start             = 1'b1;
      bus.ai_move_valid = 1'b1;
      bus.ai_move       = 9'b100000000;
      tick();
      start             = 1'b0;
      bus.ai_move_valid = 1'b0;
      bus.ai_move       = 9'd0;
      checks++;
      if ({ain, bin, winner} !== 20'd0 || {bus.a_move_ready, bus.ai_req} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL start_priority: ain=%b bin=%b winner=%b ready=%b req=%b, required 0 0 00 1 0",
                  ain, bin, winner, bus.a_move_ready, bus.ai_req);
      end
      a_play(9'b100000000);
      checks++;
      if (ain !== 9'b100000000) begin
         errors++; $display("[TB] FAIL restart_move: ain=%b, required 100000000", ain);
      end
   endtask

   task automatic test_async_reset();
      pulse_start();
      a_play(9'b000000001);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ain, bus.a_move_ready, bus.ai_req} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: ain=%b ready=%b req=%b, required 0 0 0", ain, bus.a_move_ready, bus.ai_req);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({bus.a_move_ready, bus.ai_req, game_over} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_idle: ready=%b req=%b over=%b, required 0 0 0",
                  bus.a_move_ready, bus.ai_req, game_over);
      end
   endtask

   initial begin
      test_reset();
      test_a_win();
      test_illegal();
      test_timeout();
      test_draw();
      test_b_win();
      test_win_full_board();
      test_start_in_bwait();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
